// File: rtl/p5_alu_seq.sv
// p5_alu_seq: command sequencer that wraps the 16-bit datapath ALU.
// It runs single-cycle ops (ADD/SUB/AND/NOT/CMP) and a shift-and-add MUL,
// and it holds the result and N/V/Z status registers for the control FSM.
module p5_alu_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_z
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_AND = 3'b010;
  localparam logic [2:0] C_NOT = 3'b011;
  localparam logic [2:0] C_MUL = 3'b100;
  localparam logic [2:0] C_CMP = 3'b101;

  logic [1:0]       state;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             ovf;

  logic [WIDTH-1:0] mplier_nx;
  logic [WIDTH-1:0] acc_nx;
  logic             carry;
  logic             ovf_nx;
  logic             mul_last;

  assign busy = (state == S_EXEC) || (state == S_MUL);
  assign done = (state == S_DONE);
  assign err  = done && (cmd_q > C_CMP);

  // One MUL iteration: conditional accumulate, unsigned overflow tracking, exit test.
  // Overflow also covers multiplicand bits about to be shifted out while multiplier bits remain.
  always_comb begin
    mplier_nx = mplier >> 1;
    carry     = (acc[WIDTH-1] & mcand[WIDTH-1]) |
                ((acc[WIDTH-1] | mcand[WIDTH-1]) & ~alu_out[WIDTH-1]);
    acc_nx    = mplier[0] ? alu_out : acc;
    ovf_nx    = ovf | (mplier[0] & carry) | (mcand[WIDTH-1] & (mplier_nx != '0));
    mul_last  = (count == CW'(WIDTH-1)) || (EARLY_EXIT && (mplier_nx == '0));
  end

  // ALU operand/opcode steering; idle states present zeros.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 2'b00;
    case (state)
      S_EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (cmd_q)
          C_ADD:   alu_op = 2'b00;
          C_SUB:   alu_op = 2'b01;
          C_AND:   alu_op = 2'b10;
          C_NOT:   alu_op = 2'b11;
          C_CMP:   alu_op = 2'b01;
          default: alu_op = 2'b00;
        endcase
      end
      S_MUL: begin
        alu_a  = acc;
        alu_b  = mcand;
        alu_op = 2'b00;
      end
      default: ;
    endcase
  end

  // Sequencer state, operand capture, multiplier datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cmd_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q <= cmd;
            a_q   <= opa;
            b_q   <= opb;
            if (cmd == C_MUL) begin
              if (EARLY_EXIT && (opb == '0)) begin
                result <= '0;
                flag_n <= 1'b0;
                flag_v <= 1'b0;
                flag_z <= 1'b1;
                state  <= S_DONE;
              end else begin
                acc    <= '0;
                mcand  <= opa;
                mplier <= opb;
                count  <= '0;
                ovf    <= 1'b0;
                state  <= S_MUL;
              end
            end else if (cmd <= C_CMP) begin
              state <= S_EXEC;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (cmd_q != C_CMP) result <= alu_out;
          flag_n <= alu_n;
          flag_v <= alu_v;
          flag_z <= alu_z;
          state  <= S_DONE;
        end
        S_MUL: begin
          acc    <= acc_nx;
          ovf    <= ovf_nx;
          mcand  <= mcand << 1;
          mplier <= mplier_nx;
          count  <= count + CW'(1);
          if (mul_last) begin
            result <= acc_nx;
            flag_n <= acc_nx[WIDTH-1];
            flag_z <= (acc_nx == '0);
            flag_v <= ovf_nx;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p5_alu_seq.sv
// tb_p5_alu_seq: drives two sequencers (early exit on/off), each attached to a
// behavioural 16-bit ALU, with a table of commands and a result scoreboard.
module tb_p5_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start0;
  logic [2:0]  cmd;
  logic [15:0] opa, opb;

  logic        busy1, done1, err1, n1, v1, z1, an1, av1, az1;
  logic [15:0] res1, aa1, ab1, ao1;
  logic [1:0]  aop1;
  logic        busy0, done0, err0, n0, v0, z0, an0, av0, az0;
  logic [15:0] res0, aa0, ab0, ao0;
  logic [1:0]  aop0;

  always #5 clk = ~clk;

  // Behavioural datapath ALU: returns {n, v, z, out}.
  function automatic logic [18:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        v;
    v = 1'b0;
    case (op)
      2'b00: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      2'b01: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      2'b10: s = a & b;
      default: s = ~b;
    endcase
    return {s[15], v, (s == 16'h0), s};
  endfunction

  assign {an1, av1, az1, ao1} = alu_f(aop1, aa1, ab1);
  assign {an0, av0, az0, ao0} = alu_f(aop0, aa0, ab0);

  p5_alu_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmd(cmd), .opa(opa), .opb(opb),
    .busy(busy1), .done(done1), .err(err1), .result(res1),
    .flag_n(n1), .flag_v(v1), .flag_z(z1),
    .alu_a(aa1), .alu_b(ab1), .alu_op(aop1), .alu_out(ao1),
    .alu_n(an1), .alu_v(av1), .alu_z(az1)
  );

  p5_alu_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmd(cmd), .opa(opa), .opb(opb),
    .busy(busy0), .done(done0), .err(err0), .result(res0),
    .flag_n(n0), .flag_v(v0), .flag_z(z0),
    .alu_a(aa0), .alu_b(ab0), .alu_op(aop0), .alu_out(ao0),
    .alu_n(an0), .alu_v(av0), .alu_z(az0)
  );

  typedef struct {
    bit          sel;
    logic [2:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    bit          n, v, z, e;
    int          lat;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    bit          n, v, z, e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   dcnt1 = 0;
  int   dcnt0 = 0;

  always @(posedge clk) begin
    if (done1) dcnt1++;
    if (done0) dcnt0++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sel, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input bit n, input bit v, input bit z, input bit e,
                              input int lat, input bit poke);
    vec_t t;
    t.sel = sel; t.c = c; t.a = a; t.b = b; t.r = r;
    t.n = n; t.v = v; t.z = z; t.e = e; t.lat = lat; t.poke = poke;
    return t;
  endfunction

  task automatic run_cmd(input vec_t t, input int idx);
    exp_t e, g;
    int   lat, bcnt, d0;
    logic dn, bs;
    e.r = t.r; e.n = t.n; e.v = t.v; e.z = t.z; e.e = t.e; e.lat = t.lat;
    sb.push_back(e);
    d0 = t.sel ? dcnt1 : dcnt0;
    @(negedge clk);
    cmd = t.c; opa = t.a; opb = t.b;
    if (t.sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    lat = 1; bcnt = 0;
    while (1) begin
      dn = t.sel ? done1 : done0;
      bs = t.sel ? busy1 : busy0;
      if (dn || lat >= 40) break;
      if (bs) bcnt++;
      if (t.poke && lat == 3) begin
        cmd = 3'b000; opa = 16'h0001; opb = 16'h0001;
        if (t.sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start1 = 1'b0; start0 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0; start0 = 1'b0;
    g = sb.pop_front();
    if (!dn) begin
      check($sformatf("v%0d done_timeout", idx), {31'b0, dn}, 32'd1);
      return;
    end
    check($sformatf("v%0d result", idx), t.sel ? res1 : res0, g.r);
    check($sformatf("v%0d flag_n", idx), t.sel ? n1 : n0, g.n);
    check($sformatf("v%0d flag_v", idx), t.sel ? v1 : v0, g.v);
    check($sformatf("v%0d flag_z", idx), t.sel ? z1 : z0, g.z);
    check($sformatf("v%0d err", idx), t.sel ? err1 : err0, g.e);
    check($sformatf("v%0d latency", idx), lat, g.lat);
    check($sformatf("v%0d busy_cycles", idx), bcnt, g.lat - 1);
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), t.sel ? done1 : done0, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d done_count", idx), (t.sel ? dcnt1 : dcnt0) - d0, 1);
  endtask

  initial begin
    int d_before;
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0;
    cmd = '0; opa = '0; opb = '0;

    //              sel cmd     a        b        result   n v z e lat poke
    vecs.push_back(mk(1, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1, 1, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b001, 16'h0005, 16'h0005, 16'h0000, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1, 3'b101, 16'h0003, 16'h0004, 16'h0000, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b011, 16'h1234, 16'h00FF, 16'hFF00, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b100, 16'h0012, 16'h000D, 16'h00EA, 0, 0, 0, 0, 5, 0));
    vecs.push_back(mk(1, 3'b111, 16'hAAAA, 16'h5555, 16'h00EA, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3'b110, 16'h0001, 16'h0001, 16'h00EA, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3'b100, 16'h0100, 16'h0100, 16'h0000, 0, 1, 1, 0, 10, 0));
    vecs.push_back(mk(1, 3'b100, 16'h1234, 16'h0000, 16'h0000, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 3'b111, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 3'b100, 16'hFFFF, 16'h0001, 16'hFFFF, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 3'b100, 16'h8000, 16'h0002, 16'h0000, 0, 1, 1, 0, 3, 0));
    vecs.push_back(mk(1, 3'b100, 16'h7000, 16'h0003, 16'h5000, 0, 1, 0, 0, 3, 0));
    vecs.push_back(mk(1, 3'b100, 16'h00FF, 16'h0101, 16'hFFFF, 1, 0, 0, 0, 10, 0));
    vecs.push_back(mk(0, 3'b000, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 3'b100, 16'h0012, 16'h000D, 16'h00EA, 0, 0, 0, 0, 17, 1));
    vecs.push_back(mk(0, 3'b100, 16'h1234, 16'h0000, 16'h0000, 0, 0, 1, 0, 17, 0));
    vecs.push_back(mk(0, 3'b100, 16'h00FF, 16'h0101, 16'hFFFF, 1, 0, 0, 0, 17, 0));

    repeat (2) @(negedge clk);
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst err", err1, 1'b0);
    check("rst result", res1, 16'h0);
    check("rst flags", {n1, v1, z1}, 3'b000);
    check("rst alu_a", aa1, 16'h0);
    check("rst alu_op", aop1, 2'b00);
    rst_n = 1'b1;

    foreach (vecs[i]) run_cmd(vecs[i], i);

    // Reset in the middle of a long multiply on the fixed-iteration instance.
    d_before = dcnt0;
    @(negedge clk);
    cmd = 3'b100; opa = 16'h0012; opb = 16'h000D; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    check("mid busy_before_rst", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid busy", busy0, 1'b0);
    check("mid done", done0, 1'b0);
    check("mid result", res0, 16'h0);
    check("mid flags", {n0, v0, z0}, 3'b000);
    check("mid result_ee1", res1, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid no_done", dcnt0 - d_before, 0);
    run_cmd(mk(0, 3'b000, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0, 2, 0), 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
